// File: rtl/truth_table_checker.sv
// Self-test sequencer for small combinational gates: sweeps every input vector,
// waits a settle interval, samples the gate output and scores it against EXPECT.
module truth_table_checker #(
    parameter int                  N_IN   = 2,
    parameter logic [2**N_IN-1:0]  EXPECT = 4'b1101,
    parameter int                  SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      dut_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [2**N_IN-1:0]   fail_vec,
    output logic [2**N_IN-1:0]   captured
);

    localparam int NVEC = 2**N_IN;
    localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST    = N_IN'(NVEC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [CW-1:0]     settle_cnt_q, settle_cnt_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_count_q, err_count_d;
    logic [NVEC-1:0]   fail_vec_q, fail_vec_d;
    logic [NVEC-1:0]   captured_q, captured_d;
    logic              mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            settle_cnt_q <= '0;
            dut_in_q     <= '0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            fail_vec_q   <= '0;
            captured_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_cnt_q <= settle_cnt_d;
            dut_in_q     <= dut_in_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            fail_vec_q   <= fail_vec_d;
            captured_q   <= captured_d;
        end
    end

    // pass is computed from the count including the final sample so it lines up with done.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        settle_cnt_d = settle_cnt_q;
        dut_in_d     = dut_in_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        fail_vec_d   = fail_vec_q;
        captured_d   = captured_q;
        mismatch     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_SETTLE;
                    idx_d        = '0;
                    dut_in_d     = '0;
                    settle_cnt_d = '0;
                    err_count_d  = '0;
                    fail_vec_d   = '0;
                    captured_d   = '0;
                    pass_d       = 1'b0;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d      = S_SAMPLE;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                mismatch            = (dut_out != EXPECT[idx_q]);
                captured_d[idx_q]   = dut_out;
                if (mismatch) begin
                    fail_vec_d[idx_q] = 1'b1;
                    err_count_d       = err_count_q + 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                    pass_d  = (err_count_d == '0);
                end else begin
                    state_d      = S_SETTLE;
                    idx_d        = idx_q + 1'b1;
                    dut_in_d     = idx_q + 1'b1;
                    settle_cnt_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign dut_in    = dut_in_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign fail_vec  = fail_vec_q;
    assign captured  = captured_q;

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Sequential self-test driver/checker for small combinational gate modules, e.g. a 2-input NAND-built implication cell.
- Sweeps every input combination into the unit under test, waits a settle interval, then samples the unit's output.
- Compares each sample against a parameterised expected truth table and reports captured table, per-vector mismatch map, error count and pass/fail.
- Works from the opposite side of the gate interface: it produces the gate inputs and consumes the gate output, replacing hand-written stimulus/monitor benches.

Parameters:
- N_IN, 2, number of gate inputs; vectors = 2**N_IN.
- EXPECT, 4'b1101, expected output per vector; bit k = expected output when dut_in == k. Default is s = a | ~b with dut_in = {a,b}. Width 2**N_IN.
- SETTLE, 1, cycles dut_in is held before the sample cycle. Must be >= 1; 0 is illegal.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE
- dut_out  input  1  output of the gate under test
- dut_in  output  N_IN  registered stimulus to the gate; MSB = first gate input
- busy  output  1  high in SETTLE, SAMPLE and DONE
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  1 if the last sweep had zero mismatches; held until next start
- err_count  output  N_IN+1  number of mismatching vectors in the last sweep
- fail_vec  output  2**N_IN  bit k set if vector k mismatched
- captured  output  2**N_IN  bit k = dut_out sampled for vector k

Behaviour:
- Reset: at a clk edge with reset=1:
  - state goes to IDLE;
  - dut_in, busy, done, pass, err_count, fail_vec, captured all go to 0.
  - Reset has priority over every other event, including mid-sweep; an aborted sweep produces no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE. idx is the vector counter (N_IN bits); settle_cnt counts SETTLE cycles.
- IDLE:
  - If start=1 at the edge: go to SETTLE; idx=0; dut_in=0; settle_cnt=0; clear err_count, fail_vec, captured and pass.
  - Otherwise stay in IDLE; all result outputs hold.
- SETTLE:
  - settle_cnt increments each edge.
  - At the edge where settle_cnt==SETTLE-1: go to SAMPLE.
- SAMPLE (exactly one cycle), at the closing edge:
  - captured[idx] <= dut_out.
  - If dut_out != EXPECT[idx]: fail_vec[idx] <= 1 and err_count <= err_count+1.
  - If idx == 2**N_IN-1: go to DONE.
  - Otherwise: idx <= idx+1, dut_in <= idx+1, settle_cnt <= 0, go to SETTLE.
- DONE (one cycle):
  - done=1.
  - pass = (final err_count == 0), registered on the edge entering DONE so it is valid together with done.
  - Next edge: go to IDLE, done=0.
- Latency: done is high in the cycle after edge 2**N_IN*(SETTLE+1), counting the edge that samples start as edge 0. With defaults this is edge 8.
- dut_in changes only on SAMPLE->SETTLE and IDLE->SETTLE transitions. Each vector is held for SETTLE+1 cycles.
- start is ignored in SETTLE, SAMPLE and DONE (no restart, no queueing).
- start held high continuously gives back-to-back sweeps. With defaults the period is 10 edges (8 sweep + DONE + IDLE).
- Result outputs remain stable in IDLE until the next accepted start.
- dut_out is purely combinational from dut_in, so no synchroniser is used.
- err_count width N_IN+1 cannot overflow (max 2**N_IN).

Test Plan:
- Defaults, DUT modelled as a|~b, pulse start at edge 0:
  - dut_in sequence 00,01,10,11, each held 2 cycles;
  - done in the cycle after edge 8; captured=1101, fail_vec=0000, err_count=0, pass=1.
- Defaults, DUT = a&b: captured=1000, fail_vec=0101, err_count=2, pass=0, done after edge 8.
- Defaults, DUT output stuck at 0: captured=0000, fail_vec=1101, err_count=3, pass=0.
- start held at 1 for 30 cycles with a correct DUT:
  - done pulses after edges 8, 18 and 28;
  - each accepted start clears the results; pass=1 at each done.
- Reset at edge 5 mid-sweep:
  - next cycle busy=0, dut_in=00, err_count=0, fail_vec=0, captured=0, pass=0;
  - no done pulse;
  - a new start then runs a full sweep normally.
- SETTLE=3 with a correct DUT: each vector held 4 cycles, done after edge 16, pass=1. A start pulse at edge 6 is ignored (no restart).
